irrigation_timer_bank: RTL and testbench
========================================

# irrigation_timer_bank

Parametrised multi-zone countdown timer for the irrigation controller: holds CHANNELS independent BCD tens:units counters, each loaded from a shared preset bus and decremented on a common one-cycle `tick` enable. It replaces gated-clock counting with a fully synchronous, clock-enabled design. It adds per-channel pause, abort, one-shot or auto-reload modes, and a registered expiry pulse that the irrigation FSM uses to advance zone state.

## Interface
- `CHANNELS`, default 4: number of independent zone timers.
- `CH_W`, default 2: width of the channel select. Must satisfy 2^CH_W >= CHANNELS.
- `TENS_MAX`, default 5: maximum tens digit. Full scale is TENS_MAX:9, i.e. 59 ticks.
- `TENS_W`, default 3: width of the tens digit. Must hold TENS_MAX.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  count-unit enable, one cycle high per unit. Shared by all channels.
- `load`  in  1  load strobe for channel `load_ch`.
- `load_ch`  in  CH_W  channel to load.
- `load_tens`  in  TENS_W  preset tens digit.
- `load_units`  in  4  preset units digit, BCD.
- `load_reload`  in  1  mode for the loaded channel: 1 = auto-reload, 0 = one-shot.
- `pause`  in  CHANNELS  per-channel level hold.
- `abort`  in  CHANNELS  per-channel cancel strobe.
- `tens`  out  CHANNELS*TENS_W  current tens digits; channel i at [i*TENS_W +: TENS_W].
- `units`  out  CHANNELS*4  current units digits; channel i at [i*4 +: 4].
- `busy`  out  CHANNELS  channel is in RUN or PAUSED.
- `done`  out  CHANNELS  one-cycle expiry pulse per channel.

## Operation
- **Per-channel FSM states.** IDLE, RUN, PAUSED.
  - IDLE -> RUN on a load with a non-zero preset while `pause[i]` = 0.
  - IDLE -> PAUSED on a load with a non-zero preset while `pause[i]` = 1.
  - RUN <-> PAUSED follows `pause[i]`, evaluated every cycle.
  - RUN -> IDLE on expiry in one-shot mode.
  - Any state -> IDLE on `abort[i]`.
- **Load.** A load stores the preset and the reload flag in the channel's preset registers and copies the preset into the counter.
  - Digits saturate on load: `load_units` > 9 becomes 9; `load_tens` > TENS_MAX becomes TENS_MAX.
  - A preset of 00:00 sets the counter to 0 and forces IDLE. No `done` pulse is produced.
  - A load to a RUN or PAUSED channel restarts it with the new preset.
  - `load_ch` >= CHANNELS: the load is ignored.
- **Decrement.** Applies only in RUN with `tick` = 1.
  - If units > 0, units decrements.
  - Else if tens > 0, tens decrements and units wraps to 9.
  - PAUSED and IDLE ignore `tick`.
- **Expiry.** Occurs on a decrement from 00:01.
  - One-shot mode: counter becomes 00:00, state becomes IDLE, `done[i]` pulses.
  - Auto-reload mode: counter reloads the stored preset instead of showing 00:00, state stays RUN, `done[i]` pulses.
- **Abort.** Counter goes to 00:00, state to IDLE, the reload flag is cleared, and no `done` pulse is produced.
- **Per-channel priority (highest first).** abort > load > tick.
- **Independence.** Channels are independent. One load, any number of aborts and one tick can all act in the same cycle.

## Timing
- **Reset.** While `rst_n` = 0, all counters, preset registers and reload flags are 0, all states are IDLE, and `busy` = 0 and `done` = 0. Reset is asynchronous: assertion mid-count clears immediately.
- **Registered outputs.** All outputs are registered with no combinational path from any input.
- **Load latency.** The counter shows the preset, and `busy[i]` = 1, from the edge that samples `load`.
- **Decrement latency.** The count changes on the edge that samples `tick`, one edge per tick.
- **`done[i]` timing.** `done[i]` is high for exactly one cycle, starting at the expiry edge.
  - One-shot: `busy[i]` falls on that same edge.
  - Auto-reload: `busy[i]` stays high.
- **Pause.** Pause takes effect on the next edge. A tick in the same cycle as a rising `pause[i]` is not counted.
- **Tick rate.** A `tick` held high for N cycles counts N units. There is no edge detection.

## Test plan
- **Reset and basic one-shot.**
  - Stimulus: reset, then load ch0 = 0:3 one-shot, then 3 ticks.
  - Required: `units[0]` reads 3,2,1,0. `done[0]` pulses once on the third tick edge. `busy[0]` falls on that edge.
- **Digit borrow.**
  - Stimulus: load ch1 = 2:0, then 1 tick.
  - Required: ch1 reads 1:9. After 19 more ticks it reads 0:0 with `done[1]` asserted.
- **Auto-reload.**
  - Stimulus: load ch2 = 0:2 with reload, then 6 ticks.
  - Required: sequence 2,1,2,1,2,1. `done[2]` pulses on ticks 2, 4 and 6. `busy[2]` stays 1.
- **Pause and abort.**
  - Stimulus: load ch3 = 0:5, 2 ticks, `pause[3]` = 1 for 3 ticks, release, then `abort[3]`.
  - Required: holds at 0:3 while paused, decrements after release. Abort gives 0:0 with `busy[3]` = 0 and no `done`.
- **Saturation and zero load.**
  - Stimulus 1: load `tens` = 7, `units` = 12. Required: TENS_MAX:9, i.e. 5:9.
  - Stimulus 2: load 0:0. Required: IDLE, `busy` = 0, no `done`.
- **Simultaneous events and async reset.**
  - Stimulus: abort and load to ch0 in the same cycle; separately, load plus tick in the same cycle; then drop `rst_n` mid-count.
  - Required: abort wins. Load plus tick shows the preset undecremented. Reset zeroes all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/irrigation_timer_bank_if.sv
// Interface for the zone timer bank's preset/control bus and its counter and status outputs.
// The controller drives it through the master modport, and the timer bank uses the slave modport.
interface irrigation_timer_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned TENS_W   = 3
);
    logic                         tick;
    logic                         load;
    logic [CH_W-1:0]              load_ch;
    logic [TENS_W-1:0]            load_tens;
    logic [3:0]                   load_units;
    logic                         load_reload;
    logic [CHANNELS-1:0]          pause;
    logic [CHANNELS-1:0]          abort;
    logic [CHANNELS*TENS_W-1:0]   tens;
    logic [CHANNELS*4-1:0]        units;
    logic [CHANNELS-1:0]          busy;
    logic [CHANNELS-1:0]          done;

    modport master (
        output tick, load, load_ch, load_tens, load_units, load_reload, pause, abort,
        input  tens, units, busy, done
    );

    modport slave (
        input  tick, load, load_ch, load_tens, load_units, load_reload, pause, abort,
        output tens, units, busy, done
    );
endinterface

// File: rtl/irrigation_timer_bank.sv
// Bank of independent BCD tens:units countdown timers with a shared preset bus and a common tick enable.
// Each channel has pause, abort, one-shot or auto-reload, and a registered expiry pulse.
module irrigation_timer_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned TENS_MAX = 5,
    parameter int unsigned TENS_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    irrigation_timer_bank_if.slave   bus
);

    localparam int unsigned UNITS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    state_e              state_q     [CHANNELS];
    state_e              state_d     [CHANNELS];
    logic [TENS_W-1:0]   tens_q      [CHANNELS];
    logic [TENS_W-1:0]   tens_d      [CHANNELS];
    logic [UNITS_W-1:0]  units_q     [CHANNELS];
    logic [UNITS_W-1:0]  units_d     [CHANNELS];
    logic [TENS_W-1:0]   pre_tens_q  [CHANNELS];
    logic [TENS_W-1:0]   pre_tens_d  [CHANNELS];
    logic [UNITS_W-1:0]  pre_units_q [CHANNELS];
    logic [UNITS_W-1:0]  pre_units_d [CHANNELS];
    logic [CHANNELS-1:0] reload_q, reload_d;
    logic [CHANNELS-1:0] busy_q, busy_d;
    logic [CHANNELS-1:0] done_q, done_d;

    logic [TENS_W-1:0]   sat_tens_c;
    logic [UNITS_W-1:0]  sat_units_c;
    logic                load_zero_c;
    logic                load_valid_c;

    // Saturate the shared preset once; out-of-range channel selects are dropped.
    always_comb begin
        sat_tens_c   = (bus.load_tens > TENS_W'(TENS_MAX)) ? TENS_W'(TENS_MAX) : bus.load_tens;
        sat_units_c  = (bus.load_units > UNITS_W'(9)) ? UNITS_W'(9) : bus.load_units;
        load_zero_c  = (sat_tens_c == '0) && (sat_units_c == '0);
        load_valid_c = bus.load && ({1'b0, bus.load_ch} < (CH_W+1)'(CHANNELS));
    end

    // Per-channel next state: abort beats load, and load beats tick.
    always_comb begin
        state_d     = state_q;
        tens_d      = tens_q;
        units_d     = units_q;
        pre_tens_d  = pre_tens_q;
        pre_units_d = pre_units_q;
        reload_d    = reload_q;
        done_d      = '0;
        busy_d      = '0;

        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (bus.abort[i]) begin
                state_d[i]  = ST_IDLE;
                tens_d[i]   = '0;
                units_d[i]  = '0;
                reload_d[i] = 1'b0;
            end else if (load_valid_c && (bus.load_ch == CH_W'(i))) begin
                pre_tens_d[i]  = sat_tens_c;
                pre_units_d[i] = sat_units_c;
                reload_d[i]    = bus.load_reload;
                tens_d[i]      = sat_tens_c;
                units_d[i]     = sat_units_c;
                if (load_zero_c) begin
                    state_d[i] = ST_IDLE;
                end else begin
                    state_d[i] = bus.pause[i] ? ST_PAUSED : ST_RUN;
                end
            end else begin
                unique case (state_q[i])
                    ST_RUN: begin
                        // A tick in the cycle pause rises is dropped.
                        if (bus.pause[i]) begin
                            state_d[i] = ST_PAUSED;
                        end else if (bus.tick) begin
                            if (tens_q[i] == '0 && units_q[i] == UNITS_W'(1)) begin
                                done_d[i] = 1'b1;
                                if (reload_q[i]) begin
                                    tens_d[i]  = pre_tens_q[i];
                                    units_d[i] = pre_units_q[i];
                                end else begin
                                    tens_d[i]  = '0;
                                    units_d[i] = '0;
                                    state_d[i] = ST_IDLE;
                                end
                            end else if (units_q[i] != '0) begin
                                units_d[i] = units_q[i] - UNITS_W'(1);
                            end else if (tens_q[i] != '0) begin
                                tens_d[i]  = tens_q[i] - TENS_W'(1);
                                units_d[i] = UNITS_W'(9);
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!bus.pause[i]) begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end
            busy_d[i] = (state_d[i] != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i]     <= ST_IDLE;
                tens_q[i]      <= '0;
                units_q[i]     <= '0;
                pre_tens_q[i]  <= '0;
                pre_units_q[i] <= '0;
            end
            reload_q <= '0;
            busy_q   <= '0;
            done_q   <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i]     <= state_d[i];
                tens_q[i]      <= tens_d[i];
                units_q[i]     <= units_d[i];
                pre_tens_q[i]  <= pre_tens_d[i];
                pre_units_q[i] <= pre_units_d[i];
            end
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_pack
        assign bus.tens[g*TENS_W +: TENS_W]    = tens_q[g];
        assign bus.units[g*UNITS_W +: UNITS_W] = units_q[g];
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_irrigation_timer_bank.sv
// Directed bench for irrigation_timer_bank: one-shot, borrow, reload, pause/abort, saturation, priority, async reset.
module tb_irrigation_timer_bank;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    irrigation_timer_bank_if #(.CHANNELS(4), .CH_W(2), .TENS_W(3)) bus ();

    irrigation_timer_bank #(.CHANNELS(4), .CH_W(2), .TENS_MAX(5), .TENS_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] u(input int ch);
        return 32'(bus.units[ch*4 +: 4]);
    endfunction

    function automatic logic [31:0] t(input int ch);
        return 32'(bus.tens[ch*3 +: 3]);
    endfunction

    task automatic do_load(input int ch, input int tn, input int un, input logic rl);
        bus.load        = 1'b1;
        bus.load_ch     = 2'(ch);
        bus.load_tens   = 3'(tn);
        bus.load_units  = 4'(un);
        bus.load_reload = rl;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.tick = 1'b0;
        bus.pause = '0;
        bus.abort = '0;
        bus.load = 1'b0;
        bus.load_ch = '0;
        bus.load_tens = '0;
        bus.load_units = '0;
        bus.load_reload = 1'b0;
        cyc();
        cyc();
        chk("rst_units", 32'(bus.units), 0);
        chk("rst_tens", 32'(bus.tens), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        cyc();

        // One-shot 0:3 on ch0
        do_load(0, 0, 3, 1'b0);
        cyc();
        bus.load = 1'b0;
        chk("os_load_u", u(0), 3);
        chk("os_load_busy", 32'(bus.busy[0]), 1);
        bus.tick = 1'b1;
        cyc();
        chk("os_t1_u", u(0), 2);
        cyc();
        chk("os_t2_u", u(0), 1);
        chk("os_t2_done", 32'(bus.done[0]), 0);
        cyc();
        chk("os_t3_u", u(0), 0);
        chk("os_t3_done", 32'(bus.done[0]), 1);
        chk("os_t3_busy", 32'(bus.busy[0]), 0);
        bus.tick = 1'b0;
        cyc();
        chk("os_done_drop", 32'(bus.done[0]), 0);

        // Borrow from tens: 2:0 on ch1
        do_load(1, 2, 0, 1'b0);
        cyc();
        bus.load = 1'b0;
        chk("br_load_t", t(1), 2);
        bus.tick = 1'b1;
        cyc();
        chk("br_t1_t", t(1), 1);
        chk("br_t1_u", u(1), 9);
        for (int k = 0; k < 18; k++) cyc();
        chk("br_01_u", u(1), 1);
        chk("br_01_done", 32'(bus.done[1]), 0);
        cyc();
        chk("br_end_t", t(1), 0);
        chk("br_end_u", u(1), 0);
        chk("br_end_done", 32'(bus.done[1]), 1);
        chk("br_end_busy", 32'(bus.busy[1]), 0);
        bus.tick = 1'b0;

        // Auto-reload 0:2 on ch2
        do_load(2, 0, 2, 1'b1);
        cyc();
        bus.load = 1'b0;
        chk("ar_load_u", u(2), 2);
        bus.tick = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("ar_t%0d_u", k), u(2), (k % 2 == 1) ? 1 : 2);
            chk($sformatf("ar_t%0d_done", k), 32'(bus.done[2]), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("ar_t%0d_busy", k), 32'(bus.busy[2]), 1);
        end
        bus.tick = 1'b0;
        bus.abort = 4'b0100;
        cyc();
        bus.abort = '0;
        chk("ar_abort_busy", 32'(bus.busy[2]), 0);
        chk("ar_abort_u", u(2), 0);

        // Pause then abort on ch3
        do_load(3, 0, 5, 1'b0);
        cyc();
        bus.load = 1'b0;
        bus.tick = 1'b1;
        cyc();
        cyc();
        chk("pa_run_u", u(3), 3);
        bus.pause = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("pa_hold%0d_u", k), u(3), 3);
            chk($sformatf("pa_hold%0d_busy", k), 32'(bus.busy[3]), 1);
        end
        bus.pause = '0;
        cyc();
        chk("pa_resume_u", u(3), 3);
        cyc();
        chk("pa_dec_u", u(3), 2);
        bus.tick = 1'b0;
        bus.abort = 4'b1000;
        cyc();
        bus.abort = '0;
        chk("pa_abort_u", u(3), 0);
        chk("pa_abort_busy", 32'(bus.busy[3]), 0);
        chk("pa_abort_done", 32'(bus.done[3]), 0);

        // Saturation and zero preset on ch0
        do_load(0, 7, 12, 1'b0);
        cyc();
        chk("sat_t", t(0), 5);
        chk("sat_u", u(0), 9);
        chk("sat_busy", 32'(bus.busy[0]), 1);
        do_load(0, 0, 0, 1'b0);
        cyc();
        bus.load = 1'b0;
        chk("zero_u", u(0), 0);
        chk("zero_busy", 32'(bus.busy[0]), 0);
        chk("zero_done", 32'(bus.done[0]), 0);

        // Abort beats load, load beats tick
        do_load(0, 0, 4, 1'b0);
        bus.abort = 4'b0001;
        cyc();
        bus.abort = '0;
        chk("prio_abort_busy", 32'(bus.busy[0]), 0);
        chk("prio_abort_u", u(0), 0);
        do_load(0, 0, 4, 1'b0);
        bus.tick = 1'b1;
        cyc();
        bus.load = 1'b0;
        chk("prio_load_u", u(0), 4);
        cyc();
        chk("prio_tick_u", u(0), 3);
        do_load(1, 3, 0, 1'b0);
        cyc();
        bus.load = 1'b0;
        chk("indep_u0", u(0), 2);
        chk("indep_t1", t(1), 3);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_units", 32'(bus.units), 0);
        chk("arst_tens", 32'(bus.tens), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        bus.tick = 1'b0;
        cyc();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
